// File: rtl/pipe_stage_hs.sv
// Pipeline stage register with a valid/ready handshake, flush and bubble insertion.
// Define PIPE_SKID_EN to add a skid slot, which makes ready_o a registered output.
module pipe_stage_hs #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o
);

  logic             main_v_reg, main_v_next;
  logic [WIDTH-1:0] main_d_reg, main_d_next;
  logic             in_fire, out_fire, main_free;

  assign valid_o   = main_v_reg;
  assign data_o    = main_d_reg;
  assign out_fire  = main_v_reg & ready_i;
  assign main_free = ~main_v_reg | out_fire;
  assign in_fire   = valid_i & ready_o;

`ifdef PIPE_SKID_EN
  logic             skid_v_reg, skid_v_next;
  logic [WIDTH-1:0] skid_d_reg, skid_d_next;

  // Accepting only while skid is empty keeps ready_o free of any path from ready_i.
  assign ready_o = ~skid_v_reg;

  always_comb begin
    main_v_next = main_v_reg;
    main_d_next = main_d_reg;
    skid_v_next = skid_v_reg;
    skid_d_next = skid_d_reg;
    if (main_free) begin
      if (skid_v_reg) begin
        // ready_o is low here, so no new beat can arrive in the same cycle.
        main_v_next = 1'b1;
        main_d_next = skid_d_reg;
        skid_v_next = 1'b0;
        skid_d_next = RST_VAL;
      end else if (in_fire) begin
        main_v_next = 1'b1;
        main_d_next = data_i;
      end else if (out_fire) begin
        main_v_next = 1'b0;
        main_d_next = RST_VAL;
      end
    end else if (in_fire) begin
      skid_v_next = 1'b1;
      skid_d_next = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      main_v_reg <= 1'b0;
      main_d_reg <= RST_VAL;
      skid_v_reg <= 1'b0;
      skid_d_reg <= RST_VAL;
    end else begin
      main_v_reg <= main_v_next;
      main_d_reg <= main_d_next;
      skid_v_reg <= skid_v_next;
      skid_d_reg <= skid_d_next;
    end
  end

`else
  assign ready_o = ready_i | ~main_v_reg;

  always_comb begin
    main_v_next = main_v_reg;
    main_d_next = main_d_reg;
    if (main_free && in_fire) begin
      main_v_next = 1'b1;
      main_d_next = data_i;
    end else if (out_fire) begin
      // Empty slot shows RST_VAL so a consumed beat is never left on data_o.
      main_v_next = 1'b0;
      main_d_next = RST_VAL;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      main_v_reg <= 1'b0;
      main_d_reg <= RST_VAL;
    end else begin
      main_v_reg <= main_v_next;
      main_d_reg <= main_d_next;
    end
  end
`endif

endmodule
